branch_predictor: RTL
=====================

# branch_predictor

Dynamic branch predictor and mispredict sequencer for the pipelined core. It holds a table of 2-bit saturating counters indexed by PC and issues a taken/not-taken prediction when a conditional branch is looked up. It tracks the single in-flight branch and drives the branch unit's `branchPrediction` input from that registered prediction. When the branch unit resolves the branch, the block updates the table, flags a mispredict, and sequences a one-cycle flush of the wrong-path instruction.

## Interface
Parameters:
- `DATA_W`, 16: PC width in bits.
- `IDX_W`, 4: table index width; the table has 2^IDX_W entries.

Ports:
- `clk` input, 1: rising-edge clock.
- `arst_n` input, 1: asynchronous, active-low reset.
- `lookup_valid` input, 1: a conditional branch is being fetched/decoded this cycle.
- `lookup_pc` input, DATA_W: PC of that branch.
- `pred_taken` output, 1: combinational prediction for `lookup_pc`; equals counter bit 1.
- `stall` output, 1: the lookup cannot be accepted this cycle.
- `branch_prediction` output, 1: registered prediction of the in-flight branch; feeds the branch unit.
- `pending` output, 1: a branch is in flight.
- `resolve_valid` input, 1: the branch unit resolves the in-flight branch this cycle.
- `resolve_taken` input, 1: actual outcome (branch unit's should-have-taken).
- `mispredict` output, 1: combinational; selects the branch unit's `branch_pc` as next PC.
- `flush` output, 1: registered one-cycle pulse that squashes the wrong-path instruction.
- `lookup_count` output, 16: accepted-lookup statistic (see Configuration).
- `mispredict_count` output, 16: mispredict statistic (see Configuration).

## Operation
Table:
- Index is `pc[IDX_W+1:2]`, the word-aligned PC bits.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Every entry resets to 01.
- Update rule: taken increments the counter, saturating at 11. Not-taken decrements it, saturating at 00.

Pending tracker:
- State is `pending`, `pend_idx` and `pend_pred`.
- A lookup is accepted when `lookup_valid && !stall && !mispredict`.
- On accept, next cycle: `pending`=1, `pend_idx`=index, `pend_pred`=`pred_taken`.
- `branch_prediction` = `pend_pred`.

Stall:
- `stall = lookup_valid && pending && !resolve_valid`.
- Only one branch may be in flight.

Resolution:
- Acts when `resolve_valid && pending`.
- `table[pend_idx]` is updated with `resolve_taken`.
- `mispredict = resolve_valid && pending && (resolve_taken != pend_pred)`.
- `pending` clears unless a lookup is accepted in the same cycle.
- If `resolve_valid` is asserted while `pending`=0, it is ignored: no update, no mispredict.

Simultaneous events:
- Resolve and accepted lookup in the same cycle: the new branch replaces the in-flight one.
- If the lookup index equals `pend_idx`, `pred_taken` uses the pre-update counter. There is no bypass.
- Mispredict together with `lookup_valid`: the lookup is wrong-path. It is dropped, and `pending` ends at 0.

Flush:
- `flush` at cycle N+1 equals `mispredict` at cycle N.

## Timing
- Reset values:
  - `pending`, `branch_prediction`, `flush`, `lookup_count`, `mispredict_count` = 0.
  - All counters = 01, so `pred_taken` = 0 after reset.
- Combinational paths:
  - `pred_taken` has zero latency from `lookup_pc`.
  - `stall` and `mispredict` have zero latency from their inputs.
- One-cycle latencies:
  - Accepted lookup to `branch_prediction`/`pending`.
  - Resolve to table update.
  - Mispredict to `flush`.
- Reset mid-operation clears `pending`, suppresses any `flush` pulse and reinitialises the whole table asynchronously.

## Configuration
- `BP_STATS_EN` defined:
  - `lookup_count` increments on each accepted lookup.
  - `mispredict_count` increments on each mispredict.
  - Both saturate at 16'hFFFF.
- `BP_STATS_EN` undefined:
  - Both ports are tied to 0.
  - No counter flops are built.
  - Prediction behaviour is identical in both builds.

## Test plan
- Reset, then lookup pc=0x0040 -> `pred_taken`=0. Next cycle `pending`=1 and `branch_prediction`=0.
- Resolve taken twice on pc=0x0040 (01→10→11), then lookup 0x0040 -> `pred_taken`=1. First resolve gives `mispredict`=1 and `flush`=1 one cycle later.
- Four consecutive not-taken resolves on one index -> counter saturates at 00 with no wrap. A taken resolve then yields 01.
- `lookup_valid` held with `pending`=1 and no resolve -> `stall`=1. The cycle `resolve_valid` rises -> `stall`=0 and the lookup is accepted.
- Resolve (mispredict) with simultaneous `lookup_valid` at pc=0x0044 -> lookup dropped, `pending`=0 next cycle, `flush`=1.
- With `BP_STATS_EN`: 3 accepted lookups and 1 mispredict -> `lookup_count`=3, `mispredict_count`=1. Assert `arst_n` low mid-flight -> all outputs 0 immediately.

Source files
------------

// File: rtl/branch_predictor_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor_if
// Description : Bundle of the lookup, resolve and status signals exchanged
//               between the core pipeline (master) and branch_predictor
//               (slave).
//               master drives : lookup_valid, lookup_pc, resolve_valid,
//                               resolve_taken
//               slave drives  : pred_taken, stall, branch_prediction,
//                               pending, mispredict, flush, lookup_count,
//                               mispredict_count
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_predictor_if #(
   parameter int DATA_W = 16
);
   // fetch/decode side lookup
   logic              lookup_valid;
   logic [DATA_W-1:0] lookup_pc;
   logic              pred_taken;
   logic              stall;

   // in-flight branch, feeds the branch unit
   logic              branch_prediction;
   logic              pending;

   // branch unit resolution
   logic              resolve_valid;
   logic              resolve_taken;
   logic              mispredict;
   logic              flush;

   // statistics
   logic [15:0]       lookup_count;
   logic [15:0]       mispredict_count;

   modport master (
      output lookup_valid,
      output lookup_pc,
      output resolve_valid,
      output resolve_taken,
      input  pred_taken,
      input  stall,
      input  branch_prediction,
      input  pending,
      input  mispredict,
      input  flush,
      input  lookup_count,
      input  mispredict_count
   );

   modport slave (
      input  lookup_valid,
      input  lookup_pc,
      input  resolve_valid,
      input  resolve_taken,
      output pred_taken,
      output stall,
      output branch_prediction,
      output pending,
      output mispredict,
      output flush,
      output lookup_count,
      output mispredict_count
   );
endinterface
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Dynamic branch predictor with a table of 2-bit saturating
//               counters indexed by word-aligned PC bits, a single-entry
//               in-flight branch tracker and a one-cycle mispredict flush
//               sequencer.
// Ports       : clk    - rising-edge clock
//               arst_n - asynchronous active-low reset
//               bp     - branch_predictor_if.slave (lookup, resolve, status)
// Parameters  : DATA_W - PC width
//               IDX_W  - table index width (2**IDX_W counters)
// Options     : BP_STATS_EN - when defined, lookup_count and
//               mispredict_count are saturating 16-bit statistics counters;
//               otherwise both ports read 0 and no counter flops exist.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
   parameter int DATA_W = 16,
   parameter int IDX_W  = 4
) (
   input  logic                clk,
   input  logic                arst_n,
   branch_predictor_if.slave   bp
);

   localparam int         c_ENTRIES   = 2 ** IDX_W;
   localparam logic [1:0] c_CTR_RESET = 2'b01;   // weak not-taken
   localparam logic [1:0] c_CTR_MAX   = 2'b11;   // strong taken
   localparam logic [1:0] c_CTR_MIN   = 2'b00;   // strong not-taken
   localparam logic [15:0] c_STAT_MAX = 16'hFFFF;

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [1:0]       r_table [c_ENTRIES];
   logic             r_pending;
   logic [IDX_W-1:0] r_pend_idx;
   logic             r_pend_pred;
   logic             r_flush;

   // -------------------------------------------------------------------------
   // Combinational decode
   // -------------------------------------------------------------------------
   logic [IDX_W-1:0] w_lookup_idx;
   logic             w_pred_taken;
   logic             w_stall;
   logic             w_resolve;
   logic             w_mispredict;
   logic             w_accept;
   logic [1:0]       w_ctr_cur;
   logic [1:0]       w_ctr_next;
   logic             w_unused_pc;

   // Branches are word aligned, so PC[1:0] carry no information.
   assign w_lookup_idx = bp.lookup_pc[IDX_W+1:2];
   assign w_unused_pc  = ^{bp.lookup_pc[DATA_W-1:IDX_W+2], bp.lookup_pc[1:0]};

   // Prediction reads the table as it stands this cycle; a resolve to the
   // same entry in the same cycle is not forwarded.
   assign w_pred_taken = r_table[w_lookup_idx][1];

   // Only one branch may be in flight; a resolve this cycle frees the slot.
   assign w_stall      = bp.lookup_valid && r_pending && !bp.resolve_valid;

   // A resolve with nothing in flight is ignored entirely.
   assign w_resolve    = bp.resolve_valid && r_pending;
   assign w_mispredict = w_resolve && (bp.resolve_taken != r_pend_pred);

   // A lookup seen in a mispredict cycle is on the wrong path and is dropped.
   assign w_accept     = bp.lookup_valid && !w_stall && !w_mispredict;

   // Saturating counter update for the in-flight entry.
   always_comb begin
      w_ctr_cur  = r_table[r_pend_idx];
      w_ctr_next = w_ctr_cur;
      if (bp.resolve_taken) begin
         if (w_ctr_cur != c_CTR_MAX) begin
            w_ctr_next = w_ctr_cur + 2'd1;
         end
      end else begin
         if (w_ctr_cur != c_CTR_MIN) begin
            w_ctr_next = w_ctr_cur - 2'd1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Counter table
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int i = 0; i < c_ENTRIES; i++) begin
            r_table[i] <= c_CTR_RESET;
         end
      end else if (w_resolve) begin
         r_table[r_pend_idx] <= w_ctr_next;
      end
   end

   // -------------------------------------------------------------------------
   // In-flight tracker and flush sequencer
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_pending   <= 1'b0;
         r_pend_idx  <= '0;
         r_pend_pred <= 1'b0;
         r_flush     <= 1'b0;
      end else begin
         if (w_accept) begin
            // Also covers resolve+lookup: the new branch replaces the old.
            r_pending   <= 1'b1;
            r_pend_idx  <= w_lookup_idx;
            r_pend_pred <= w_pred_taken;
         end else if (w_resolve) begin
            r_pending   <= 1'b0;
         end
         r_flush <= w_mispredict;
      end
   end

   // -------------------------------------------------------------------------
   // Statistics
   // -------------------------------------------------------------------------
`ifdef BP_STATS_EN
   logic [15:0] r_lookup_count;
   logic [15:0] r_mispredict_count;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_lookup_count     <= '0;
         r_mispredict_count <= '0;
      end else begin
         if (w_accept && (r_lookup_count != c_STAT_MAX)) begin
            r_lookup_count <= r_lookup_count + 16'd1;
         end
         if (w_mispredict && (r_mispredict_count != c_STAT_MAX)) begin
            r_mispredict_count <= r_mispredict_count + 16'd1;
         end
      end
   end

   assign bp.lookup_count     = r_lookup_count;
   assign bp.mispredict_count = r_mispredict_count;
`else
   assign bp.lookup_count     = 16'd0;
   assign bp.mispredict_count = 16'd0;
`endif

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign bp.pred_taken        = w_pred_taken;
   assign bp.stall             = w_stall;
   assign bp.pending           = r_pending;
   assign bp.branch_prediction = r_pend_pred;
   assign bp.mispredict        = w_mispredict;
   assign bp.flush             = r_flush;

endmodule
`default_nettype wire
